// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, sync pulses, blanking, frame strobe and frame counter.
// Latency: counters/active/frame_start zero-latency; hs/vs/blank_n delayed PIPE_DELAY enabled cycles; enable=0 freezes all state.
module vga_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int PIPE_DELAY      = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        active,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region bounds are 11 bits so a 1024 total never truncates an end bound to zero.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_RESET = '{hs: SYNC_OFF, vs: SYNC_OFF, blank_n: 1'b0};

    generate
        if (H_TOTAL > 1024) begin : g_h_total_chk
            $error("vga_timing_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_chk
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_pipe_chk
            $error("vga_timing_gen: PIPE_DELAY must be 0..4");
        end
    endgenerate

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic [15:0] r_frame_count;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    sync_t       w_raw;
    sync_t       w_out;

    assign w_h      = {1'b0, r_hcount};
    assign w_v      = {1'b0, r_vcount};
    assign w_h_last = (w_h == H_LAST);
    assign w_v_last = (w_v == V_LAST);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_count <= '0;
        end else if (enable) begin
            if (w_h_last) begin
                r_hcount <= '0;
                if (w_v_last) begin
                    r_vcount      <= '0;
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_vcount <= r_vcount + 10'd1;
                end
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    assign w_active = (w_h < H_VIS) && (w_v < V_VIS);
    assign w_hs_on  = (w_h >= HS_START) && (w_h < HS_END);
    assign w_vs_on  = (w_v >= VS_START) && (w_v < VS_END);

    assign w_raw.hs      = w_hs_on ? SYNC_ON : SYNC_OFF;
    assign w_raw.vs      = w_vs_on ? SYNC_ON : SYNC_OFF;
    assign w_raw.blank_n = w_active;

    // Sync/blank follow the registered pixel path, so the delay line only moves on enabled cycles.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign w_out = w_raw;
        end else begin : g_delay
            sync_t r_pipe [PIPE_DELAY];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= SYNC_RESET;
                    end
                end else if (enable) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_out = r_pipe[PIPE_DELAY-1];
        end
    endgenerate

    // Gating with reset_n keeps the strobe quiet while the raster is held at (0,0).
    assign frame_start = reset_n && enable && (r_hcount == 10'd0) && (r_vcount == 10'd0);

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign active      = w_active;
    assign frame_count = r_frame_count;
    assign vga_hs      = w_out.hs;
    assign vga_vs      = w_out.vs;
    assign vga_blank_n = w_out.blank_n;

endmodule
